// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: key constants, matrix sizes,
// FSM state encoding and the scan-limit clamp helper.
package keypad_pkg;

  localparam int ROW_W     = 4;
  localparam int COL_W     = 3;
  localparam int ROW_IDX_W = 2;

  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;
  localparam logic [3:0] KEY_NONE = 4'd11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // A scan limit of zero behaves as one; anything beyond the counter range saturates.
  function automatic int unsigned clamp_cnt(input int unsigned v, input int unsigned w);
    int unsigned lim;
    lim = (32'd1 << w) - 32'd1;
    if (v == 0) return 1;
    if (v > lim) return lim;
    return v;
  endfunction

endpackage

// File: rtl/keypad_code_map.sv
// Combinational key code -> (row index, column one-hot) map for the 4x3 matrix.
module keypad_code_map
  import keypad_pkg::*;
(
  input  logic [3:0]           key_code_i,
  output logic [ROW_IDX_W-1:0] row_o,
  output logic [COL_W-1:0]     col_o,
  output logic                 ok_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    row_o = '0;
    col_o = '0;
    ok_o  = 1'b1;
    case (key_code_i)
      4'd1:     begin row_o = 2'd0; col_o = 3'b001; end
      4'd2:     begin row_o = 2'd0; col_o = 3'b010; end
      4'd3:     begin row_o = 2'd0; col_o = 3'b100; end
      4'd4:     begin row_o = 2'd1; col_o = 3'b001; end
      4'd5:     begin row_o = 2'd1; col_o = 3'b010; end
      4'd6:     begin row_o = 2'd1; col_o = 3'b100; end
      4'd7:     begin row_o = 2'd2; col_o = 3'b001; end
      4'd8:     begin row_o = 2'd2; col_o = 3'b010; end
      4'd9:     begin row_o = 2'd2; col_o = 3'b100; end
      KEY_STAR: begin row_o = 2'd3; col_o = 3'b001; end
      4'd0:     begin row_o = 2'd3; col_o = 3'b010; end
      KEY_HASH: begin row_o = 2'd3; col_o = 3'b100; end
      KEY_NONE: ok_o = 1'b0;
      default:  ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/keypad_emulator.sv
// Virtual 4x3 keypad: presses handshaked key codes onto the column lines for a
// number of row scans. Define KEYEMU_BOUNCE_EN to add contact chatter at press start.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_SCANS = 4,
  parameter int unsigned GAP_SCANS  = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned BOUNCE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key_code,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [ROW_W-1:0] filas,
  output logic [COL_W-1:0] columnas,
  output logic             busy,
  output logic             err
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(clamp_cnt(HOLD_SCANS, CNT_W));
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(clamp_cnt(GAP_SCANS, CNT_W));

  state_e               state_q, state_d;
  logic [ROW_IDX_W-1:0] row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [CNT_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [ROW_W-1:0]     filas_prev_q;
  logic                 err_q, err_d;

  logic [ROW_IDX_W-1:0] map_row;
  logic [COL_W-1:0]     map_col;
  logic                 map_ok;
  logic                 scan_tick;
  logic                 press_start;
  logic [CNT_W-1:0]     cnt_inc;
  logic [COL_W-1:0]     press_cols;

  keypad_code_map u_map (
    .key_code_i (key_code),
    .row_o      (map_row),
    .col_o      (map_col),
    .ok_o       (map_ok)
  );

  assign scan_tick   = (filas == 4'b0001) && (filas_prev_q != 4'b0001);
  assign press_start = (state_q == IDLE) && key_valid && map_ok;
  assign cnt_inc     = scan_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          if (map_ok) begin
            state_d    = PRESS;
            row_d      = map_row;
            col_d      = map_col;
            scan_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PRESS: begin
        if (scan_tick) begin
          if (cnt_inc == HOLD_LIM) begin
            state_d    = RELEASE;
            scan_cnt_d = '0;
          end else begin
            scan_cnt_d = cnt_inc;
          end
        end
      end
      RELEASE: begin
        if (scan_tick) begin
          if (cnt_inc == GAP_LIM) begin
            state_d    = IDLE;
            scan_cnt_d = '0;
          end else begin
            scan_cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      scan_cnt_q   <= '0;
      filas_prev_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      scan_cnt_q   <= scan_cnt_d;
      filas_prev_q <= filas;
      err_q        <= err_d;
    end
  end

  // Combinational: the scanner reads columns in the same cycle it drives a row.
  assign press_cols = ((state_q == PRESS) && filas[row_q]) ? col_q : '0;

`ifdef KEYEMU_BOUNCE_EN
  localparam logic [CNT_W-1:0] BOUNCE_LIM = CNT_W'(BOUNCE_CYC);

  logic [CNT_W-1:0] bounce_q, bounce_d;
  logic             in_window;

  assign in_window = (bounce_q < BOUNCE_LIM);

  always_comb begin
    bounce_d = bounce_q;
    if (press_start) begin
      bounce_d = '0;
    end else if ((state_q == PRESS) && in_window) begin
      bounce_d = bounce_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bounce_q <= '0;
    end else begin
      bounce_q <= bounce_d;
    end
  end

  assign columnas = press_cols & {COL_W{~in_window | bounce_q[1]}};
`else
  logic unused_bounce;
  assign unused_bounce = ^{BOUNCE_CYC, press_start};
  assign columnas      = press_cols;
`endif

  assign key_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: per-cycle model comparison plus
// hand-computed expectations for each directed scenario.
module tb_keypad_emulator;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] filas;
  logic [2:0] columnas;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_SCANS (HOLD),
    .GAP_SCANS  (GAP),
    .CNT_W      (8),
    .BOUNCE_CYC (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .filas     (filas),
    .columnas  (columnas),
    .busy      (busy),
    .err       (err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_phase = 0;   // 0 idle, 1 pressing, 2 gap
  int       m_left  = 0;   // scans remaining in current phase
  int       m_code  = 0;
  int       m_pc    = 0;   // cycles spent pressing
  bit       m_err   = 0;
  bit       m_live  = 0;
  bit       m_tick;
  logic [3:0] m_prev = '0;

  function automatic bit code_valid(input int c);
    return (c <= 9) || (c == 14) || (c == 15);
  endfunction

  function automatic int code_row(input int c);
    if (c == 0 || c >= 14) return 3;
    return (c - 1) / 3;
  endfunction

  function automatic int code_col(input int c);
    if (c == 14) return 1;
    if (c == 0)  return 2;
    if (c == 15) return 4;
    return 1 << ((c - 1) % 3);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_err = 0; m_prev = '0; m_pc = 0; m_live = 1;
    end else begin
      m_tick = (filas == 4'b0001) && (m_prev != 4'b0001);
      m_err  = 0;
      case (m_phase)
        0: if (key_valid) begin
             if (code_valid(int'(key_code))) begin
               m_phase = 1; m_left = HOLD; m_code = int'(key_code); m_pc = 0;
             end else begin
               m_err = 1;
             end
           end
        1: begin
             m_pc++;
             if (m_tick) begin
               m_left--;
               if (m_left == 0) begin m_phase = 2; m_left = GAP; end
             end
           end
        default: if (m_tick) begin
             m_left--;
             if (m_left == 0) m_phase = 0;
           end
      endcase
      m_prev = filas;
    end
  end

  function automatic logic [2:0] exp_cols();
    int c;
    if (m_phase != 1) return 3'b000;
    c = filas[code_row(m_code)] ? code_col(m_code) : 0;
`ifdef KEYEMU_BOUNCE_EN
    if (m_pc < 16 && ((m_pc / 2) % 2) == 0) c = 0;
`endif
    return 3'(c);
  endfunction

  always @(negedge clk) begin
    if (m_live) begin
      check("columnas", columnas, exp_cols());
      check("key_ready", key_ready, m_phase == 0);
      check("busy", busy, m_phase != 0);
      check("err", err, m_err);
    end
  end

  // ---------------- scenario observers ----------------
  int lit_mode = 0;
  int c_nz, c_010, c_busy, c_err, c_nready, c_bad;
  logic [2:0] seq[$];

  task automatic clr_lit();
    c_nz = 0; c_010 = 0; c_busy = 0; c_err = 0; c_nready = 0; c_bad = 0;
    seq.delete();
  endtask

  always @(negedge clk) begin
    if (lit_mode != 0) begin
      if (columnas != 3'b000) c_nz++;
      if (columnas == 3'b010) c_010++;
      if (busy) c_busy++;
      if (err) c_err++;
      if (!key_ready) c_nready++;
      if (lit_mode == 1 && columnas != 3'b000 && !(columnas == 3'b010 && filas == 4'b0010)) c_bad++;
      if (lit_mode == 2 && columnas != 3'b000) begin
        if (filas != 4'b1000) c_bad++;
        if (seq.size() == 0 || seq[$] != columnas) seq.push_back(columnas);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit scan_on = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (scan_on) filas = (filas == 4'b1000 || filas == 4'b0000) ? 4'b0001 : (filas << 1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (m_phase != 0 && n < limit) begin cyc(); n++; end
    @(negedge clk);
    check(name, key_ready, 1);
  endtask

  task automatic align_row0();
    int n = 0;
    while (filas != 4'b0001 && n < 8) begin cyc(); n++; end
  endtask

`ifdef KEYEMU_BOUNCE_EN
  logic [23:0] cap;
`endif

  initial begin
    rst_n = 0; key_valid = 0; key_code = '0; filas = '0;
    repeat (3) cyc();
    @(negedge clk);
    check("rst_columnas", columnas, 3'b000);
    check("rst_ready", key_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    cyc();
    rst_n = 1;

    // Code 5 with free-running scanner, accepted while row0 is driven.
    scan_on = 1;
    cyc();
    align_row0();
    clr_lit(); lit_mode = 1;
    key_code = 4'd5; key_valid = 1;
    cyc();
    key_valid = 0;
    wait_idle("t1_idle", 200);
    repeat (4) cyc();
    lit_mode = 0;
    check("t1_col010_cycles", c_010, 4);
    check("t1_col_active", c_nz, 4);
    check("t1_bad_cols", c_bad, 0);
    check("t1_busy_cycles", c_busy, 24);

    // Back-to-back 14, 0, 15 with key_valid held high.
    begin
      int codes[$];
      int n = 0;
      bit acc;
      codes = '{14, 0, 15};
      clr_lit(); lit_mode = 2;
      key_valid = 1; key_code = 4'(codes[0]);
      while (codes.size() > 0 && n < 400) begin
        acc = (m_phase == 0);
        cyc(); n++;
        if (acc) begin
          void'(codes.pop_front());
          if (codes.size() > 0) key_code = 4'(codes[0]);
          else key_valid = 0;
        end
      end
      check("t2_all_sent", codes.size(), 0);
      key_valid = 0;
      wait_idle("t2_idle", 200);
      lit_mode = 0;
      check("t2_seq_len", seq.size(), 3);
      if (seq.size() == 3) begin
        check("t2_seq0", seq[0], 3'b001);
        check("t2_seq1", seq[1], 3'b010);
        check("t2_seq2", seq[2], 3'b100);
      end
      check("t2_off_row", c_bad, 0);
    end

    // Invalid code 12.
    clr_lit(); lit_mode = 3;
    key_code = 4'd12; key_valid = 1;
    cyc();
    key_valid = 0;
    repeat (8) cyc();
    lit_mode = 0;
    check("t3_err_cycles", c_err, 1);
    check("t3_busy", c_busy, 0);
    check("t3_cols", c_nz, 0);
    check("t3_not_ready", c_nready, 0);

    // Reset during the press of code 9, after the second scan.
    align_row0();
    key_code = 4'd9; key_valid = 1;
    cyc();
    key_valid = 0;
    repeat (8) cyc();
    check("t4_pressing", m_phase, 1);
    rst_n = 0;
    cyc();
    @(negedge clk);
    check("t4_filas_row2", filas, 4'b0100);
    check("t4_cols_after_rst", columnas, 3'b000);
    check("t4_ready_after_rst", key_ready, 1);
    check("t4_busy_after_rst", busy, 0);
    cyc();
    rst_n = 1;
    clr_lit(); lit_mode = 4;
    repeat (30) cyc();
    lit_mode = 0;
    check("t4_residual_cols", c_nz, 0);
    check("t4_residual_busy", c_busy, 0);

    // Stalled scanner on row2 with code 8.
    scan_on = 0; filas = 4'b0100;
    key_code = 4'd8; key_valid = 1;
    cyc();
    key_valid = 0;
    clr_lit(); lit_mode = 5;
    repeat (50) cyc();
    lit_mode = 0;
    check("t5_cols_held", c_010, 50);
    check("t5_busy_held", c_busy, 50);
    rst_n = 0;
    cyc();
    rst_n = 1;

`ifdef KEYEMU_BOUNCE_EN
    filas = 4'b0001;
    cyc();
    key_code = 4'd1; key_valid = 1;
    cyc();
    key_valid = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      cap[i] = columnas[0];
      cyc();
    end
    check("t6_bounce_pattern", cap, 24'hFFCCCC);
    rst_n = 0;
    cyc();
    rst_n = 1;
`endif

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
